sipo_deser: RTL and testbench

Serial-in/parallel-out deserializer. It is the receive end of the team's 4-bit PISO serial link. It samples one bit per enabled clock and assembles WIDTH-bit words. Each completed word is presented on a holding register with a valid/ready handshake, and a sticky flag reports dropped words. It sits between a serial line source and a parallel consumer.

---
 rtl/sipo_deser_if.sv | 24 ++
 rtl/sipo_deser.sv | 48 ++++
 tb/tb_sipo_deser.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial-in and parallel-out handshake bundle for sipo_deser.
//   master: drives shift_en, serial_in, frame_start, out_ready, overrun_clr;
//           observes parallel_out, out_valid, overrun, bit_cnt
//   slave : the deserializer side (directions reversed)
interface sipo_deser_if #(parameter int WIDTH = 4);
    localparam int CW = $clog2(WIDTH);
    logic             shift_en;
    logic             serial_in;
    logic             frame_start;
    logic             out_ready;
    logic             overrun_clr;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             overrun;
    logic [CW-1:0]    bit_cnt;
    modport master (
        output shift_en, serial_in, frame_start, out_ready, overrun_clr,
        input  parallel_out, out_valid, overrun, bit_cnt
    );
    modport slave (
        input  shift_en, serial_in, frame_start, out_ready, overrun_clr,
        output parallel_out, out_valid, overrun, bit_cnt
    );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with valid/ready holding register.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sipo_deser_if.slave (serial input, frame realign, parallel output
//          handshake, sticky overrun flag with clear, partial-word bit count)
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input logic         clk,
    input logic         rst,
    sipo_deser_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] shreg, base, shifted, hold;
    logic [CW-1:0]    cnt, cnt_base, cnt_nx;
    logic             valid, ovr, complete, load, drop;
    // frame_start realigns before the sample, so a same-edge bit becomes bit 0
    always_comb begin
        base     = bus.frame_start ? '0 : shreg;
        cnt_base = bus.frame_start ? '0 : cnt;
        shifted  = MSB_FIRST ? {base[WIDTH-2:0], bus.serial_in}
                             : {bus.serial_in, base[WIDTH-1:1]};
        complete = bus.shift_en && (cnt_base == CW'(WIDTH-1));
        cnt_nx   = !bus.shift_en ? cnt_base : complete ? '0 : cnt_base + 1'b1;
        load     = complete && (!valid || bus.out_ready);
        drop     = complete && valid && !bus.out_ready;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            hold  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            shreg <= bus.shift_en ? shifted : base;
            cnt   <= cnt_nx;
            hold  <= load ? shifted : hold;
            valid <= load || (valid && !bus.out_ready);
            ovr   <= drop || (ovr && !bus.overrun_clr);
        end
    end
    assign bus.parallel_out = hold;
    assign bus.out_valid    = valid;
    assign bus.overrun      = ovr;
    assign bus.bit_cnt      = cnt;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: checks MSB-first and LSB-first sipo_deser instances against a bit-queue model.
module tb_sipo_deser;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    sipo_deser_if #(.WIDTH(W)) ia ();
    sipo_deser_if #(.WIDTH(W)) ib ();
    sipo_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    sipo_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    always #5 clk = ~clk;
    // reference: bits of the current frame in arrival order, plus holding state
    logic q[$];
    logic [W-1:0] ma = '0, mb = '0, wa, wb;
    logic mv = 1'b0, mo = 1'b0, done, drop;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            ma = '0;
            mb = '0;
            mv = 1'b0;
            mo = 1'b0;
        end else begin
            done = 1'b0;
            if (ia.frame_start) q.delete();
            if (ia.shift_en) begin
                q.push_back(ia.serial_in);
                if (q.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wa[W-1-i] = q[i];
                        wb[i]     = q[i];
                    end
                    q.delete();
                end
            end
            drop = done && mv && !ia.out_ready;
            if (done && !drop) begin
                ma = wa;
                mb = wb;
                mv = 1'b1;
            end else if (mv && ia.out_ready) mv = 1'b0;
            mo = drop || (mo && !ia.overrun_clr);
        end
    end
    always @(negedge clk) begin
        chk("po_msb", ia.parallel_out, ma);
        chk("po_lsb", ib.parallel_out, mb);
        chk("valid_msb", ia.out_valid, mv);
        chk("valid_lsb", ib.out_valid, mv);
        chk("ovr_msb", ia.overrun, mo);
        chk("ovr_lsb", ib.overrun, mo);
        chk("cnt_msb", ia.bit_cnt, q.size());
        chk("cnt_lsb", ib.bit_cnt, q.size());
    end
    task automatic set_in(input logic se, si, fs, rdy, clr);
        ia.shift_en = se; ia.serial_in = si; ia.frame_start = fs; ia.out_ready = rdy; ia.overrun_clr = clr;
        ib.shift_en = se; ib.serial_in = si; ib.frame_start = fs; ib.out_ready = rdy; ib.overrun_clr = clr;
    endtask
    task automatic drive(input logic se, si, fs, rdy, clr);
        set_in(se, si, fs, rdy, clr);
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [W-1:0] bits, input logic rdy, input logic gaps);
        for (int i = W - 1; i >= 0; i--) begin
            drive(1, bits[i], 0, rdy, 0);
            if (gaps && i > 0) drive(0, 0, 0, rdy, 0);
        end
    endtask
    initial begin
        set_in(0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            chk("rst_po", ia.parallel_out, 0);
            chk("rst_valid", ia.out_valid, 0);
            chk("rst_ovr", ib.overrun, 0);
            chk("rst_cnt", ia.bit_cnt, 0);
        end
        set_in(0, 0, 0, 1, 0);
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        send(4'b1011, 1, 0);
        chk("basic_msb", ia.parallel_out, 4'b1011);
        chk("basic_lsb", ib.parallel_out, 4'b1101);
        chk("basic_valid", ia.out_valid, 1);
        chk("basic_cnt", ia.bit_cnt, 0);
        drive(0, 0, 0, 1, 0);
        chk("basic_one_cycle", ia.out_valid, 0);
        send(4'b1011, 0, 1);
        drive(0, 0, 0, 0, 0);
        send(4'b0110, 0, 1);
        chk("stall_hold_msb", ia.parallel_out, 4'b1011);
        chk("stall_hold_lsb", ib.parallel_out, 4'b1101);
        chk("stall_valid", ia.out_valid, 1);
        chk("stall_ovr", ia.overrun, 1);
        drive(0, 0, 0, 0, 1);
        chk("ovr_clr", ia.overrun, 0);
        drive(0, 0, 0, 1, 0);
        chk("drain_valid", ia.out_valid, 0);
        send(4'b1011, 0, 0);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        chk("simul_msb", ia.parallel_out, 4'b0110);
        chk("simul_lsb", ib.parallel_out, 4'b0110);
        chk("simul_valid", ia.out_valid, 1);
        chk("simul_ovr", ia.overrun, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 0);
        chk("realign_cnt", ia.bit_cnt, 1);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        chk("realign_msb", ia.parallel_out, 4'b0011);
        chk("realign_lsb", ib.parallel_out, 4'b1100);
        drive(1, 1, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        chk("mid_cnt", ia.bit_cnt, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_cnt", ia.bit_cnt, 0);
        drive(0, 0, 0, 1, 0);
        rst = 1'b0;
        send(4'b0101, 1, 0);
        chk("clean_msb", ia.parallel_out, 4'b0101);
        chk("clean_lsb", ib.parallel_out, 4'b1010);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        drive(0, 0, 0, 1, 0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
